// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings, FSM states and defaults for the load/store unit.
package lsu_pkg;
    localparam logic [1:0] MOP_RSV  = 2'b00;
    localparam logic [1:0] MOP_BYTE = 2'b01;
    localparam logic [1:0] MOP_HALF = 2'b10;
    localparam logic [1:0] MOP_WORD = 2'b11;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    function automatic logic is_aligned(logic [1:0] op, logic [1:0] a);
        return op == MOP_WORD ? a == 2'b00 : op == MOP_HALF ? !a[0] : op == MOP_BYTE;
    endfunction
endpackage

// File: rtl/lsu_lane_gen.sv
// lsu_lane_gen: byte enables and write-lane replication for a sized access.
module lsu_lane_gen
    import lsu_pkg::*;
(
    input  logic [1:0]  mem_op,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata
);
    always_comb begin
        be = mem_op == MOP_WORD ? 4'b1111 :
             mem_op == MOP_HALF ? (addr[1] ? 4'b1100 : 4'b0011) :
             mem_op == MOP_BYTE ? 4'b0001 << addr : 4'b0000;
        lane_wdata = mem_op == MOP_BYTE ? {4{wdata[7:0]}} :
                     mem_op == MOP_HALF ? {2{wdata[15:0]}} : wdata;
    end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store controller with alignment check and
// wait timeout; loads return the raw word for the register-file write port.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [1:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [1:0]  rf_memop,
    output logic [1:0]  rf_addr,
    output logic        busy,
    output logic        done,
    output logic        align_err,
    output logic        timeout_err
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, wdata_q, rdata_q, lane_wdata;
    logic [1:0]    op_q;
    logic [4:0]    rd_q;
    logic [3:0]    be_q, be;
    logic          we_q, align_q, to_q, ok, last, accept;

    lsu_lane_gen u_lane (
        .mem_op     (mem_op),
        .addr       (addr[1:0]),
        .wdata      (wdata),
        .be         (be),
        .lane_wdata (lane_wdata)
    );

    always_comb begin
        ok      = is_aligned(mem_op, addr[1:0]);
        last    = cnt_q == CW'(TIMEOUT - 1);
        accept  = state_q == S_IDLE && start && ok;
        // an ack in the final wait cycle takes priority over the timeout
        state_d = state_q == S_IDLE ? (accept ? S_WAIT : S_IDLE) :
                  state_q == S_WAIT ? (mem_ack ? S_RESP : last ? S_IDLE : S_WAIT) : S_IDLE;
        cnt_d   = state_q == S_WAIT && !mem_ack && !last ? cnt_q + 1'b1 : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            align_q <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            align_q <= state_q == S_IDLE && start && !ok;
            to_q    <= state_q == S_WAIT && !mem_ack && last;
            if (accept) begin
                addr_q  <= addr;
                op_q    <= mem_op;
                we_q    <= is_store;
                rd_q    <= rd;
                be_q    <= be;
                wdata_q <= is_store ? lane_wdata : '0;
            end
            if (state_q == S_WAIT && mem_ack && !we_q)
                rdata_q <= mem_rdata;
        end
    end

    always_comb begin
        busy        = state_q != S_IDLE;
        mem_req     = state_q == S_WAIT;
        mem_we      = we_q;
        mem_addr    = {addr_q[31:2], 2'b00};
        mem_be      = be_q;
        mem_wdata   = wdata_q;
        done        = state_q == S_RESP || align_q || to_q;
        align_err   = align_q;
        timeout_err = to_q;
        rf_we       = state_q == S_RESP && !we_q && rd_q != 5'd0;
        rf_waddr    = rd_q;
        rf_wdata    = rdata_q;
        rf_memop    = op_q;
        rf_addr     = addr_q[1:0];
    end
endmodule
